// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first through one
// full-subtractor cell and a borrow flop, WIDTH clocks per operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] res_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    d_bit    = sa_reg[0] ^ sb_reg[0] ^ br_reg;
    br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
    res_next = {d_bit, res_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          res_reg <= res_next;
          br_reg  <= br_next;
          cnt_reg <= cnt_reg + 1'b1;
          // The last bit's result and borrow go straight to the outputs.
          if (cnt_reg == LAST_BIT) begin
            diff      <= res_next;
            bout      <= br_next;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random
// operands checked against plain unsigned arithmetic.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_vec = 0;
  int n_chk = 0;
  int miscompares = 0;

  logic [W-1:0] prev_diff;
  logic         prev_bout;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation with fixed latency checks; pulse_at>0 re-pulses start mid-run
  // with fresh operands, which must be ignored.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int pulse_at);
    logic [W-1:0] ed;
    logic         eb;
    ed = x - y;
    eb = (x < y);
    start = 1'b1;
    a = x;
    b = y;
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
    for (int k = 1; k <= W; k++) begin
      if (k == pulse_at) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      step();
      if (k == pulse_at) start = 1'b0;
      check("busy_run", busy, 1);
      if (k < W) begin
        check("done_early", done, 0);
        check("diff_hold", diff, prev_diff);
        check("bout_hold", bout, prev_bout);
      end else begin
        check("done_pulse", done, 1);
        check("diff_result", diff, ed);
        check("bout_result", bout, eb);
      end
    end
    step();
    check("done_drop", done, 0);
    check("busy_drop", busy, 0);
    check("diff_keep", diff, ed);
    check("bout_keep", bout, eb);
    prev_diff = ed;
    prev_bout = eb;
    n_vec++;
    $display("op %0d: a=%02h b=%02h -> diff=%02h bout=%0b", n_vec, x, y, diff, bout);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_diff", diff, prev_diff);
    end
  endtask

  logic [W-1:0] bx [3];
  logic [W-1:0] by [3];
  logic [W-1:0] rd [3];
  logic         rb [3];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    prev_diff = '0;
    prev_bout = 1'b0;
    idle_check(3);

    do_op(8'h05, 8'h03, 0);
    do_op(8'h03, 8'h05, 0);
    do_op(8'h00, 8'h01, 0);
    do_op(8'hFF, 8'hFF, 0);
    do_op(8'h00, 8'h00, 0);

    // Mid-run start pulse must not queue a second operation.
    do_op(8'hC4, 8'h3B, 3);
    idle_check(12);

    // Reset during RUN aborts without a done pulse.
    start = 1'b1;
    a = 8'h5A;
    b = 8'h33;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    prev_diff = '0;
    prev_bout = 1'b0;
    idle_check(12);
    do_op(8'h80, 8'h01, 0);

    // start held high: three operations, done every W+2 cycles.
    for (int i = 0; i < 3; i++) begin
      bx[i] = W'($urandom);
      by[i] = W'($urandom);
      rd[i] = bx[i] - by[i];
      rb[i] = (bx[i] < by[i]);
    end
    start = 1'b1;
    a = bx[0];
    b = by[0];
    step();
    for (int c = 1; c <= 29; c++) begin
      if (c == 29) start = 1'b0;
      step();
      check("b2b_done", done, ((c % 10) == 8) ? 1 : 0);
      check("b2b_busy", busy, ((c % 10) == 9) ? 0 : 1);
      if (c < 8) begin
        check("b2b_diff", diff, prev_diff);
      end else begin
        check("b2b_diff", diff, rd[(c - 8) / 10]);
        check("b2b_bout", bout, rb[(c - 8) / 10]);
      end
      if (c == 1 || c == 11) begin
        a = bx[c / 10 + 1];
        b = by[c / 10 + 1];
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      $display("op %0d: a=%02h b=%02h -> expect diff=%02h bout=%0b (back-to-back)",
               n_vec, bx[i], by[i], rd[i], rb[i]);
    end
    prev_diff = rd[2];
    prev_bout = rb[2];
    idle_check(3);

    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom), W'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
